bcd_adder_4digits: RTL and testbench

//   4-digit (16-bit packed BCD) decimal adder with carry-in and carry-out.

---
 rtl/bcd_adder_4digits.sv | 69 ++++++
 tb/tb_bcd_adder_4digits.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bcd_adder_4digits.sv
// bcd_adder_4digits: 4-digit packed-BCD adder, carry in/out, 1-cycle latency.
// Ports: clk, rst_n (async, active low), a/b (16-bit packed BCD),
//   cin, in_valid -> sum (16-bit BCD), cout, out_valid (all registered).
// Optional: define BCD_ERR_CHECK_EN to add err, which flags any nibble > 9
//   in a or b on accept.
module bcd_adder_4digits (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] a,
  input  logic [15:0] b,
  input  logic        cin,
  input  logic        in_valid,
  output logic [15:0] sum,
  output logic        cout,
  output logic        out_valid
`ifdef BCD_ERR_CHECK_EN
  ,
  output logic        err
`endif
);

  logic [4:0]  c;
  logic [4:0]  t [4];
  logic [15:0] d;

  assign c[0] = cin;

  // Each digit: binary add, then +6 when above 9.
  // The carry ripples to the next digit.
  for (genvar i = 0; i < 4; i++) begin : g_dig
    assign t[i] = {1'b0, a[4*i+3:4*i]}
                + {1'b0, b[4*i+3:4*i]}
                + {4'b0, c[i]};
    assign c[i+1] = (t[i] > 5'd9);
    assign d[4*i+3:4*i] = c[i+1]
                        ? t[i][3:0] + 4'd6
                        : t[i][3:0];
  end

`ifdef BCD_ERR_CHECK_EN
  logic [7:0] nib_bad;

  for (genvar i = 0; i < 4; i++) begin : g_chk
    assign nib_bad[i]   = (a[4*i+3:4*i] > 4'd9);
    assign nib_bad[i+4] = (b[4*i+3:4*i] > 4'd9);
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum       <= 16'h0000;
      cout      <= 1'b0;
      out_valid <= 1'b0;
`ifdef BCD_ERR_CHECK_EN
      err       <= 1'b0;
`endif
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        sum  <= d;
        cout <= c[4];
`ifdef BCD_ERR_CHECK_EN
        err  <= |nib_bad;
`endif
      end
    end
  end

endmodule

// File: tb/tb_bcd_adder_4digits.sv
// tb_bcd_adder_4digits: scoreboard bench for bcd_adder_4digits.
// Expected results are queued on accept and popped one cycle later.
module tb_bcd_adder_4digits;

  logic        clk;
  logic        rst_n;
  logic [15:0] a;
  logic [15:0] b;
  logic        cin;
  logic        in_valid;
  logic [15:0] sum;
  logic        cout;
  logic        out_valid;
`ifdef BCD_ERR_CHECK_EN
  logic        err;
`endif

  typedef struct packed {
    logic [15:0] s;
    logic        c;
    logic        e;
  } exp_t;

  exp_t sbq[$];
  exp_t ex;
  int   total;
  int   bad;

  bcd_adder_4digits dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .in_valid  (in_valid),
    .sum       (sum),
    .cout      (cout),
    .out_valid (out_valid)
`ifdef BCD_ERR_CHECK_EN
    ,
    .err       (err)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: time limit hit, total=%0d bad=%0d",
             total, bad);
    $fatal(1, "watchdog");
  end

  function automatic int dec(input logic [15:0] x);
    return x[15:12] * 1000 + x[11:8] * 100 + x[7:4] * 10 + x[3:0];
  endfunction

  function automatic logic [15:0] tobcd(input int v);
    logic [15:0] r;
    r[15:12] = 4'((v / 1000) % 10);
    r[11:8]  = 4'((v / 100) % 10);
    r[7:4]   = 4'((v / 10) % 10);
    r[3:0]   = 4'(v % 10);
    return r;
  endfunction

  // Decimal reference for valid BCD operands.
  function automatic exp_t model(input logic [15:0] x,
                                 input logic [15:0] y,
                                 input logic ci);
    exp_t r;
    int   s;
    s   = dec(x) + dec(y) + int'(ci);
    r.s = tobcd(s % 10000);
    r.c = (s >= 10000);
    r.e = 1'b0;
    return r;
  endfunction

  // Drive one cycle of stimulus, push if accepted, land at posedge+1.
  task automatic step(input logic [15:0] ia, input logic [15:0] ib,
                      input logic ic, input logic iv, input exp_t e);
    a        = ia;
    b        = ib;
    cin      = ic;
    in_valid = iv;
    if (iv) sbq.push_back(e);
    @(posedge clk);
    #1;
  endtask

  function automatic exp_t pop();
    exp_t r;
    r = '0;
    if (sbq.size() != 0) r = sbq.pop_front();
    return r;
  endfunction

  task automatic test_reset();
    rst_n    = 1'b0;
    a        = '0;
    b        = '0;
    cin      = 1'b0;
    in_valid = 1'b0;
    #13;
    total++;
    if (sum !== 16'h0000 || cout !== 1'b0 || out_valid !== 1'b0) begin
      bad++;
      $display("FAIL reset: got sum=%h cout=%b ov=%b want 0000/0/0",
               sum, cout, out_valid);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_basic();
    step(16'h1234, 16'h2345, 1'b0, 1'b1, exp_t'({16'h3579, 1'b0, 1'b0}));
    ex = pop();
    total++;
    if (sum !== ex.s || cout !== ex.c || out_valid !== 1'b1) begin
      bad++;
      $display("FAIL basic1: got %h/%b ov=%b want %h/%b ov=1",
               sum, cout, out_valid, ex.s, ex.c);
    end
    step(16'h5678, 16'h4321, 1'b1, 1'b1, exp_t'({16'h0000, 1'b1, 1'b0}));
    ex = pop();
    total++;
    if (sum !== ex.s || cout !== ex.c || out_valid !== 1'b1) begin
      bad++;
      $display("FAIL basic2: got %h/%b ov=%b want %h/%b ov=1",
               sum, cout, out_valid, ex.s, ex.c);
    end
  endtask

  task automatic test_wrap();
    step(16'h9999, 16'h0001, 1'b0, 1'b1, exp_t'({16'h0000, 1'b1, 1'b0}));
    ex = pop();
    total++;
    if (sum !== ex.s || cout !== ex.c) begin
      bad++;
      $display("FAIL wrap1: got %h/%b want %h/%b",
               sum, cout, ex.s, ex.c);
    end
    step(16'h8976, 16'h7894, 1'b0, 1'b1, exp_t'({16'h6870, 1'b1, 1'b0}));
    ex = pop();
    total++;
    if (sum !== ex.s || cout !== ex.c) begin
      bad++;
      $display("FAIL wrap2: got %h/%b want %h/%b",
               sum, cout, ex.s, ex.c);
    end
  endtask

  task automatic test_max_hold();
    step(16'h9999, 16'h9999, 1'b1, 1'b1, exp_t'({16'h9999, 1'b1, 1'b0}));
    ex = pop();
    total++;
    if (sum !== ex.s || cout !== ex.c || out_valid !== 1'b1) begin
      bad++;
      $display("FAIL max: got %h/%b ov=%b want %h/%b ov=1",
               sum, cout, out_valid, ex.s, ex.c);
    end
    for (int k = 0; k < 2; k++) begin
      step(16'h1111, 16'h2222, 1'b0, 1'b0, exp_t'('0));
      total++;
      if (sum !== 16'h9999 || cout !== 1'b1 || out_valid !== 1'b0) begin
        bad++;
        $display("FAIL hold%0d: got %h/%b ov=%b want 9999/1 ov=0",
                 k, sum, cout, out_valid);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [15:0] ra;
    logic [15:0] rb;
    logic        rc;
    for (int k = 0; k < 40; k++) begin
      ra = tobcd(int'($urandom_range(0, 9999)));
      rb = tobcd(int'($urandom_range(0, 9999)));
      rc = 1'($urandom_range(0, 1));
      step(ra, rb, rc, 1'b1, model(ra, rb, rc));
      ex = pop();
      total++;
      if (sum !== ex.s || cout !== ex.c || out_valid !== 1'b1) begin
        bad++;
        $display("FAIL b2b%0d: %h+%h+%b got %h/%b ov=%b want %h/%b",
                 k, ra, rb, rc, sum, cout, out_valid, ex.s, ex.c);
      end
    end
  endtask

  task automatic test_async_reset();
    step(16'h4444, 16'h4444, 1'b0, 1'b1, exp_t'({16'h8888, 1'b0, 1'b0}));
    ex = pop();
    total++;
    if (sum !== ex.s || cout !== ex.c) begin
      bad++;
      $display("FAIL pre_rst: got %h/%b want %h/%b",
               sum, cout, ex.s, ex.c);
    end
    a        = 16'h5555;
    b        = 16'h5555;
    cin      = 1'b1;
    in_valid = 1'b1;
    #2;
    rst_n = 1'b0;
    #1;
    total++;
    if (sum !== 16'h0000 || cout !== 1'b0 || out_valid !== 1'b0) begin
      bad++;
      $display("FAIL async_rst: got %h/%b ov=%b want 0000/0 ov=0",
               sum, cout, out_valid);
    end
    @(posedge clk);
    #1;
    total++;
    if (sum !== 16'h0000 || out_valid !== 1'b0) begin
      bad++;
      $display("FAIL rst_held: got %h ov=%b want 0000 ov=0",
               sum, out_valid);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    step(16'h0505, 16'h0707, 1'b1, 1'b1, exp_t'({16'h1213, 1'b0, 1'b0}));
    ex = pop();
    total++;
    if (sum !== ex.s || cout !== ex.c || out_valid !== 1'b1) begin
      bad++;
      $display("FAIL post_rst: got %h/%b ov=%b want %h/%b ov=1",
               sum, cout, out_valid, ex.s, ex.c);
    end
  endtask

`ifdef BCD_ERR_CHECK_EN
  task automatic test_err();
    step(16'h00A0, 16'h0000, 1'b0, 1'b1, exp_t'({16'h0100, 1'b0, 1'b1}));
    ex = pop();
    total++;
    if (err !== ex.e || sum !== ex.s || cout !== ex.c) begin
      bad++;
      $display("FAIL err1: got err=%b %h/%b want err=%b %h/%b",
               err, sum, cout, ex.e, ex.s, ex.c);
    end
    step(16'h0090, 16'h0000, 1'b0, 1'b1, exp_t'({16'h0090, 1'b0, 1'b0}));
    ex = pop();
    total++;
    if (err !== ex.e || sum !== ex.s) begin
      bad++;
      $display("FAIL err2: got err=%b %h want err=%b %h",
               err, sum, ex.e, ex.s);
    end
  endtask
`endif

  initial begin
    total = 0;
    bad   = 0;
    test_reset();
    test_basic();
    test_wrap();
    test_max_hold();
    test_back_to_back();
    test_async_reset();
`ifdef BCD_ERR_CHECK_EN
    test_err();
`endif
    total++;
    if (sbq.size() != 0) begin
      bad++;
      $display("FAIL sb_drain: got %0d left want 0", sbq.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
